// File: rtl/writeback_unit_pkg.sv
// Shared types for the integer register-file writeback path.
package writeback_unit_pkg;

    typedef logic [31:0] word;
    typedef logic [4:0]  reg_index_t;

    // One buffered LSU result: destination register and its value.
    typedef struct packed {
        reg_index_t rd;
        word        data;
    } wb_entry_t;

    localparam int NUM_REGS = 32;

    // Register x0 is hard-wired to zero: never written, never pending.
    function automatic logic is_zero_reg(input reg_index_t idx);
        return (idx == '0);
    endfunction

endpackage

// File: rtl/writeback_unit_fifo.sv
// wb_fifo: DEPTH-entry FIFO of wb_entry_t with registered occupancy count.
// DEPTH must be a power of two (pointers wrap naturally).
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  wb_entry_t              i_din,
    input  logic                   i_pop,
    output wb_entry_t              o_dout,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    wb_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == DEPTH_C);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: drives the register-file write port from registered outputs,
// merging single-cycle ALU results (priority) with buffered LSU results, and
// tracks in-flight load destinations so decode can stall on RAW hazards.
// Optional macro WB_FORWARD_EN: mask hazard for the index being written this
// cycle (the register file commits on negedge, so the read is valid in time).
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    output logic        hazard,
    output logic        rd_w,
    output logic [4:0]  rd_index,
    output logic [31:0] rd_in
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic                r_rd_w;
    logic [4:0]          r_rd_index;
    logic [31:0]         r_rd_in;
    logic                r_from_lsu;
    logic [NUM_REGS-1:0] r_pending;

    logic [NUM_REGS-1:0] w_pending_next;
    wb_entry_t           w_push_entry;
    wb_entry_t           w_head;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic                w_hz1;
    logic                w_hz2;

    // Full means no accept even if a pop happens this cycle: no pass-through.
    assign lsu_ready    = !w_full;
    assign w_push       = lsu_valid && lsu_ready;
    assign w_pop        = !alu_valid && !w_empty;
    assign w_push_entry = '{rd: lsu_rd, data: lsu_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Registered write port: ALU first, else oldest LSU entry, else idle with payload held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_w     <= 1'b0;
            r_rd_index <= '0;
            r_rd_in    <= '0;
            r_from_lsu <= 1'b0;
        end else if (alu_valid) begin
            r_rd_w     <= !is_zero_reg(alu_rd);
            r_rd_index <= alu_rd;
            r_rd_in    <= alu_data;
            r_from_lsu <= 1'b0;
        end else if (w_pop) begin
            r_rd_w     <= !is_zero_reg(w_head.rd);
            r_rd_index <= w_head.rd;
            r_rd_in    <= w_head.data;
            r_from_lsu <= 1'b1;
        end else begin
            r_rd_w     <= 1'b0;
            r_from_lsu <= 1'b0;
        end
    end

    // Next scoreboard: clear the load being written now, then set new issues (set wins).
    always_comb begin
        w_pending_next = r_pending;
        if (r_rd_w && r_from_lsu) begin
            w_pending_next[r_rd_index] = 1'b0;
        end
        if (issue_valid && !is_zero_reg(issue_rd)) begin
            w_pending_next[issue_rd] = 1'b1;
        end
    end

    // Scoreboard register; bit 0 can never be set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Hazard lookup for both decode sources; x0 never stalls.
    always_comb begin
        w_hz1 = !is_zero_reg(chk_rs1) && r_pending[chk_rs1];
        w_hz2 = !is_zero_reg(chk_rs2) && r_pending[chk_rs2];
`ifdef WB_FORWARD_EN
        if (r_rd_w && (chk_rs1 == r_rd_index)) w_hz1 = 1'b0;
        if (r_rd_w && (chk_rs2 == r_rd_index)) w_hz2 = 1'b0;
`else
        w_hz1 = w_hz1;
        w_hz2 = w_hz2;
`endif
    end

    assign hazard   = w_hz1 || w_hz2;
    assign rd_w     = r_rd_w;
    assign rd_index = r_rd_index;
    assign rd_in    = r_rd_in;

`ifndef SYNTHESIS
    // Decode must never let an ALU result target a register with a load in flight.
    always @(posedge clk) begin
        if (rst_n && alu_valid && r_pending[alu_rd]) begin
            $error("writeback_unit: ALU write to pending register x%0d", alu_rd);
        end
        if (rst_n && (w_count > DEPTH_C)) begin
            $error("writeback_unit: LSU buffer count overflow %0d", w_count);
        end
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed table, hand-written
// multi-cycle sequences, then randomized traffic against a queue-based model.
module tb_writeback_unit;

    localparam int DEPTH = 4;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        hazard;
    logic        rd_w;
    logic [4:0]  rd_index;
    logic [31:0] rd_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] tb_regs [32];

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .hazard      (hazard),
        .rd_w        (rd_w),
        .rd_index    (rd_index),
        .rd_in       (rd_in)
    );

    always #5 clk = ~clk;

    // Register file stand-in: commits on negedge.
    always @(negedge clk) begin
        if (rd_w) tb_regs[rd_index] <= rd_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    endtask

    typedef struct {
        logic        alu_valid;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        exp_w;
        logic        chk_payload;
        logic [4:0]  exp_idx;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Reference model state
    ent_t        q[$];
    bit          pend [32];
    logic        m_rd_w;
    logic [4:0]  m_idx;
    logic [31:0] m_data;
    logic        m_lsu;

    function automatic bit model_hz(input logic [4:0] rs);
        if (rs == 0 || !pend[rs]) return 1'b0;
        if (FWD && m_rd_w && m_idx == rs) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        vec_t vecs [6];
        for (int i = 0; i < 32; i++) tb_regs[i] = '0;

        // ---- Reset values ----
        idle_inputs();
        rst_n = 0;
        #3;
        check("reset_rd_w", rd_w, 0);
        check("reset_rd_index", rd_index, 0);
        check("reset_rd_in", rd_in, 0);
        check("reset_lsu_ready", lsu_ready, 1);
        check("reset_hazard", hazard, 0);
        tick();
        rst_n = 1;
        tick();

        // ---- Table: ALU path, x0 suppression, idle hold ----
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd31, 32'h00000001, 1'b1, 1'b1, 5'd31, 32'h00000001};
        vecs[2] = '{1'b0, 5'd9,  32'h11111111, 1'b0, 1'b1, 5'd31, 32'h00000001};
        vecs[3] = '{1'b1, 5'd0,  32'h0000CAFE, 1'b0, 1'b0, 5'd0,  32'h0};
        vecs[4] = '{1'b1, 5'd12, 32'h0000A5A5, 1'b1, 1'b1, 5'd12, 32'h0000A5A5};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd12, 32'h0000A5A5};
        for (int i = 0; i < 6; i++) begin
            alu_valid = vecs[i].alu_valid;
            alu_rd    = vecs[i].alu_rd;
            alu_data  = vecs[i].alu_data;
            tick();
            check($sformatf("tbl%0d_rd_w", i), rd_w, vecs[i].exp_w);
            if (vecs[i].chk_payload) begin
                check($sformatf("tbl%0d_rd_index", i), rd_index, vecs[i].exp_idx);
                check($sformatf("tbl%0d_rd_in", i), rd_in, vecs[i].exp_data);
            end
        end
        idle_inputs();
        tick();
        check("regfile_x5", tb_regs[5], 32'hDEADBEEF);
        check("regfile_x0_untouched", tb_regs[0], 32'h0);

        // ---- Load-use: issue x7, LSU returns, hazard timing ----
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0; chk_rs1 = 7;
        #1;
        check("lu_hazard_set", hazard, 1);
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
        tick();
        lsu_valid = 0;
        check("lu_no_write_n1", rd_w, 0);
        check("lu_hazard_n1", hazard, 1);
        tick();
        check("lu_rd_w_n2", rd_w, 1);
        check("lu_rd_index_n2", rd_index, 7);
        check("lu_rd_in_n2", rd_in, 32'h1234);
        check("lu_hazard_n2", hazard, FWD ? 0 : 1);
        tick();
        check("lu_rd_w_n3", rd_w, 0);
        check("lu_hazard_n3", hazard, 0);
        idle_inputs();

        // ---- Fill under ALU traffic, then in-order drain ----
        alu_valid = 1; alu_rd = 3;
        for (int i = 0; i < 4; i++) begin
            alu_data = 32'h300 + i;
            lsu_valid = 1; lsu_rd = 5'(10 + i); lsu_data = 32'h100 + i;
            #1;
            check($sformatf("fill%0d_ready", i), lsu_ready, 1);
            tick();
        end
        lsu_valid = 0;
        check("fill_full_ready", lsu_ready, 0);
        check("fill_alu_out", rd_in, 32'h303);
        alu_valid = 0;
        lsu_valid = 1; lsu_rd = 5'd30; lsu_data = 32'hBAD;
        #1;
        check("full_pop_ready", lsu_ready, 0);
        tick();
        lsu_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_rd_w", i), rd_w, 1);
            check($sformatf("drain%0d_rd_index", i), rd_index, 10 + i);
            check($sformatf("drain%0d_rd_in", i), rd_in, 32'h100 + i);
            tick();
        end
        check("drain_done_rd_w", rd_w, 0);
        check("drain_ready", lsu_ready, 1);

        // ---- x0 handling on LSU and scoreboard ----
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hF00;
        tick();
        check("x0_n1_rd_w", rd_w, 0);
        lsu_rd = 9; lsu_data = 32'h99;
        tick();
        lsu_valid = 0;
        check("x0_lsu_rd_w", rd_w, 0);
        tick();
        check("x0_next_rd_w", rd_w, 1);
        check("x0_next_rd_index", rd_index, 9);
        check("x0_next_rd_in", rd_in, 32'h99);
        issue_valid = 1; issue_rd = 0;
        tick();
        issue_valid = 0; chk_rs1 = 0; chk_rs2 = 0;
        #1;
        check("x0_hazard", hazard, 0);
        tick();

        // ---- Reset mid-drain ----
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_rd = 5'(20 + i);
            tick();
        end
        issue_valid = 0;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        for (int i = 0; i < 3; i++) begin
            lsu_valid = 1; lsu_rd = 5'(20 + i); lsu_data = 32'h200 + i;
            tick();
        end
        lsu_valid = 0; alu_valid = 0; chk_rs1 = 21; chk_rs2 = 22;
        tick();
        check("rst_pre_rd_index", rd_index, 20);
        check("rst_pre_hazard", hazard, 1);
        #1;
        rst_n = 0;
        #1;
        check("rst_mid_rd_w", rd_w, 0);
        check("rst_mid_ready", lsu_ready, 1);
        check("rst_mid_hazard", hazard, 0);
        tick();
        tick();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rst_post%0d_rd_w", i), rd_w, 0);
        end
        check("rst_post_hazard", hazard, 0);
        check("rst_post_ready", lsu_ready, 1);
        idle_inputs();
        tick();

        // ---- Randomized traffic against the model ----
        for (int i = 0; i < 32; i++) pend[i] = 0;
        m_rd_w = 0; m_idx = 0; m_data = 0; m_lsu = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [4:0] r;
            bit push, pop;
            ent_t e;
            alu_valid = ($urandom_range(0, 9) < 3);
            r = 5'($urandom_range(0, 31));
            if (pend[r]) r = 0;
            alu_rd = r; alu_data = $urandom;
            lsu_valid = ($urandom_range(0, 9) < 6);
            lsu_rd = 5'($urandom_range(0, 31)); lsu_data = $urandom;
            issue_valid = ($urandom_range(0, 9) < 3);
            issue_rd = 5'($urandom_range(0, 31));
            chk_rs1 = 5'($urandom_range(0, 31));
            chk_rs2 = (cyc % 2 == 0) ? m_idx : 5'($urandom_range(0, 31));
            #1;
            check("rnd_lsu_ready", lsu_ready, (q.size() != DEPTH));
            check("rnd_hazard", hazard, model_hz(chk_rs1) || model_hz(chk_rs2));
            push = lsu_valid && (q.size() != DEPTH);
            pop  = !alu_valid && (q.size() != 0);
            if (m_rd_w && m_lsu) pend[m_idx] = 0;
            if (issue_valid && issue_rd != 0) pend[issue_rd] = 1;
            if (alu_valid) begin
                m_rd_w = (alu_rd != 0); m_idx = alu_rd; m_data = alu_data; m_lsu = 0;
            end else if (pop) begin
                e = q.pop_front();
                m_rd_w = (e.rd != 0); m_idx = e.rd; m_data = e.data; m_lsu = 1;
            end else begin
                m_rd_w = 0; m_lsu = 0;
            end
            if (push) q.push_back('{rd: lsu_rd, data: lsu_data});
            tick();
            check("rnd_rd_w", rd_w, m_rd_w);
            if (m_rd_w) begin
                check("rnd_rd_index", rd_index, m_idx);
                check("rnd_rd_in", rd_in, m_data);
            end
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
